serial_rx: RTL and testbench

Byte-level UART receiver feeding the serial front end. Synchronises the asynchronous `Rx` line, recovers 8N1 frames with 16x oversampling and majority-vote sampling, and buffers good bytes in a small first-word-fall-through FIFO. The framing logic that assembles `PT` and `Key` and drives `ProgramSelector` pops bytes from it. Framing and overrun errors are flagged, never silently merged into data.

---
 rtl/serial_pkg.sv | 26 ++
 rtl/serial_rx_fifo.sv | 75 +++++++
 rtl/serial_rx.sv | 139 +++++++++++++
 tb/tb_serial_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the UART receiver: FSM encoding, oversampling
// geometry and the byte type carried through the FIFO.
`default_nettype none

package serial_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] SAMPLE_LO   = 4'd7;
  localparam logic [3:0] SAMPLE_MID  = 4'd8;
  localparam logic [3:0] SAMPLE_HI   = 4'd9;
  localparam logic [3:0] SAMPLE_LAST = 4'(OVERSAMPLE - 1);

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_rx_fifo.sv
// First-word-fall-through byte FIFO with a sticky overrun flag for bytes
// that arrive while full and unpopped.
`default_nettype none

module serial_rx_fifo
  import serial_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic  Clk,
  input  logic  Rst,
  input  logic  push_i,
  input  byte_t data_i,
  input  logic  pop_i,
  output byte_t data_o,
  output logic  valid_o,
  output logic  overrun_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  byte_t         mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   count_q;
  logic          overrun_q;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop_i && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge Clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
      if (push_i && full && !do_pop) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign valid_o   = !empty;
  assign data_o    = empty ? '0 : mem_q[rd_q];
  assign overrun_o = overrun_q;

endmodule

`default_nettype wire

// File: rtl/serial_rx.sv
// 8N1 UART receiver: two-flop synchroniser, 16x oversampling with a 7/8/9
// majority vote, framing-error detection and a FWFT byte FIFO.
`default_nettype none

module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic [7:0] RxData,
  output logic       RxValid,
  input  logic       RxPop,
  output logic       FrameErr,
  output logic       Overrun,
  output logic       Busy
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

  logic          rx_meta_q;
  logic          rxs_q;
  state_t        state_q;
  logic [TW-1:0] tick_cnt_q;
  logic [3:0]    samp_q;
  logic [2:0]    bit_q;
  logic          s_lo_q;
  logic          s_mid_q;
  byte_t         shift_q;
  logic          frame_err_q;

  logic tick;
  logic decide;
  logic maj;
  logic push;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rxs_q     <= rx_meta_q;
    end
  end

  assign tick   = (tick_cnt_q == TICK_LAST);
  assign decide = tick && (samp_q == SAMPLE_HI);
  // The third vote is the live sample taken on the decision tick itself.
  assign maj    = (s_lo_q & s_mid_q) | (s_lo_q & rxs_q) | (s_mid_q & rxs_q);
  assign push   = (state_q == ST_STOP) && decide && maj;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      samp_q      <= '0;
      bit_q       <= '0;
      s_lo_q      <= 1'b1;
      s_mid_q     <= 1'b1;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      tick_cnt_q  <= tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) begin
        samp_q <= samp_q + 1'b1;
        if (samp_q == SAMPLE_LO)  s_lo_q  <= rxs_q;
        if (samp_q == SAMPLE_MID) s_mid_q <= rxs_q;
      end

      unique case (state_q)
        ST_IDLE: begin
          samp_q <= '0;
          bit_q  <= '0;
          if (!rxs_q) begin
            state_q    <= ST_START;
            tick_cnt_q <= '0;
          end
        end
        ST_START: begin
          if (decide && maj) begin
            state_q <= ST_IDLE;
          end else if (tick && (samp_q == SAMPLE_LAST)) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide) begin
            shift_q <= {maj, shift_q[7:1]};
          end
          if (tick && (samp_q == SAMPLE_LAST)) begin
            bit_q <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (decide) begin
            if (maj) begin
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rxs_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  serial_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .push_i   (push),
    .data_i   (shift_q),
    .pop_i    (RxPop),
    .data_o   (RxData),
    .valid_o  (RxValid),
    .overrun_o(Overrun)
  );

  assign FrameErr = frame_err_q;
  assign Busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_rx.sv
// Directed and randomized bench for serial_rx against a queue-based model
// of the receive FIFO and the 8N1 frame timing.
`default_nettype none
`timescale 1ns/1ps

module tb_serial_rx;

  localparam int CLK_HZ     = 7_372_800;
  localparam int BAUD       = 115200;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_CLKS   = CLK_HZ / BAUD;
  localparam int DIV        = CLK_HZ / (BAUD * 16);
  // Edge-to-IDLE-exit is 3 clocks, the stop decision is the 10th oversample
  // tick of the 10th bit period; RxValid follows one clock later.
  localparam int DECIDE_LAT = 3 + DIV * 10 + 9 * BIT_CLKS;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Rx;
  logic       RxPop;
  logic [7:0] RxData;
  logic       RxValid;
  logic       FrameErr;
  logic       Overrun;
  logic       Busy;

  serial_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Rx      (Rx),
    .RxData  (RxData),
    .RxValid (RxValid),
    .RxPop   (RxPop),
    .FrameErr(FrameErr),
    .Overrun (Overrun),
    .Busy    (Busy)
  );

  always #5 Clk = ~Clk;

  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rise_cyc = -1;
  int   fe_cnt   = 0;
  int   frame_t0 = 0;
  logic prev_valid = 1'b0;

  logic [7:0] model_q[$];
  logic       exp_ovr = 1'b0;

  always @(posedge Clk) begin
    cyc++;
    #2;
    if (RxValid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
    prev_valid = RxValid;
    if (FrameErr === 1'b1) fe_cnt++;
  end

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Called at a negedge; drives start, 8 data bits LSB first, then stop.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] bits;
    bits     = {stop, d, 1'b0};
    frame_t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      Rx = bits[i];
      tick_n(BIT_CLKS);
    end
    Rx = 1'b1;
  endtask

  task automatic model_push(input logic [7:0] d);
    if (model_q.size() < FIFO_DEPTH) model_q.push_back(d);
    else exp_ovr = 1'b1;
  endtask

  task automatic check_head(input string tag);
    chk({tag, "_valid"}, {31'd0, RxValid}, {31'd0, model_q.size() != 0});
    if (model_q.size() != 0) chk({tag, "_data"}, {24'd0, RxData}, {24'd0, model_q[0]});
  endtask

  task automatic pop_and_check(input string tag);
    RxPop = 1'b1;
    @(negedge Clk);
    RxPop = 1'b0;
    if (model_q.size() != 0) void'(model_q.pop_front());
    check_head(tag);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    model_q.delete();
    exp_ovr = 1'b0;
  endtask

  initial begin
    logic [7:0] fill [5];
    logic [9:0] bits;
    int fe0;

    Rst = 1'b1; Rx = 1'b1; RxPop = 1'b0;
    tick_n(4);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_data",    {24'd0, RxData},   32'd0);
    chk("rst_valid",   {31'd0, RxValid},  32'd0);
    chk("rst_frameerr",{31'd0, FrameErr}, 32'd0);
    chk("rst_overrun", {31'd0, Overrun},  32'd0);
    chk("rst_busy",    {31'd0, Busy},     32'd0);

    // Single byte with exact decision-to-valid latency.
    fe0 = fe_cnt; rise_cyc = -1;
    send_frame(8'hA5, 1'b1);
    model_push(8'hA5);
    chk("a5_latency", rise_cyc - frame_t0, DECIDE_LAT);
    check_head("a5");
    chk("a5_frameerr", fe_cnt - fe0, 32'd0);
    pop_and_check("a5_pop");

    // Fill past depth without pops.
    fill = '{8'h00, 8'hFF, 8'h3C, 8'hC3, 8'h55};
    foreach (fill[i]) begin
      send_frame(fill[i], 1'b1);
      model_push(fill[i]);
      tick_n(2);
    end
    chk("ovr_set", {31'd0, Overrun}, {31'd0, exp_ovr});
    for (int i = 0; i < 4; i++) pop_and_check("ovr_drain");

    // Full FIFO, pop coincident with the 5th push.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(fill[i], 1'b1);
      model_push(fill[i]);
      tick_n(2);
    end
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(negedge Clk);
        while (cyc < frame_t0 + DECIDE_LAT - 1) @(negedge Clk);
        RxPop = 1'b1;
        @(negedge Clk);
        RxPop = 1'b0;
      end
    join
    void'(model_q.pop_front());
    model_push(8'h55);
    chk("simul_ovr", {31'd0, Overrun}, {31'd0, exp_ovr});
    check_head("simul_head");
    for (int i = 0; i < 4; i++) pop_and_check("simul_drain");

    // Held-low break: one FrameErr, no byte.
    fe0 = fe_cnt;
    Rx = 1'b0;
    tick_n(20 * BIT_CLKS);
    Rx = 1'b1;
    tick_n(8);
    chk("brk_fe_count", fe_cnt - fe0, 32'd1);
    chk("brk_valid", {31'd0, RxValid}, 32'd0);
    chk("brk_busy",  {31'd0, Busy},    32'd0);
    send_frame(8'h81, 1'b1);
    model_push(8'h81);
    check_head("after_brk");
    pop_and_check("after_brk_pop");

    // 3-clock glitch: false start only.
    fe0 = fe_cnt;
    Rx = 1'b0;
    tick_n(3);
    Rx = 1'b1;
    tick_n(3);
    chk("glitch_busy_hi", {31'd0, Busy}, 32'd1);
    tick_n(BIT_CLKS - 6);
    chk("glitch_busy_lo", {31'd0, Busy}, 32'd0);
    chk("glitch_fe", fe_cnt - fe0, 32'd0);
    check_head("glitch_nopush");

    // Reset during data bit 4 with a byte already queued.
    send_frame(8'h5A, 1'b1);
    model_push(8'h5A);
    check_head("pre_rst");
    bits = {1'b1, 8'h0F, 1'b0};
    for (int i = 0; i < 5; i++) begin
      Rx = bits[i];
      tick_n(BIT_CLKS);
    end
    Rx = bits[5];
    tick_n(20);
    chk("midrst_busy", {31'd0, Busy}, 32'd1);
    Rx = 1'b1;
    do_reset();
    chk("midrst_data",    {24'd0, RxData},   32'd0);
    chk("midrst_valid",   {31'd0, RxValid},  32'd0);
    chk("midrst_frameerr",{31'd0, FrameErr}, 32'd0);
    chk("midrst_overrun", {31'd0, Overrun},  32'd0);
    chk("midrst_busy0",   {31'd0, Busy},     32'd0);
    tick_n(5);
    send_frame(8'h7E, 1'b1);
    model_push(8'h7E);
    check_head("after_rst");
    pop_and_check("after_rst_pop");

    // Random bytes, gaps and pops against the queue model.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      int npop;
      d = 8'($urandom);
      tick_n($urandom_range(0, 16));
      send_frame(d, 1'b1);
      model_push(d);
      check_head("rnd_head");
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) pop_and_check("rnd_pop");
    end
    chk("rnd_overrun", {31'd0, Overrun}, {31'd0, exp_ovr});
    for (int k = 0; k < FIFO_DEPTH + 1; k++) pop_and_check("rnd_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
